// File: rtl/sample_stream_ctrl_if.sv
// Bundle of the UART-in / DAC-out signals of sample_stream_ctrl.
// slave  : the controller's view (consumes in_*, drives out_*).
// master : the surrounding system's view (drives in_*, consumes out_*).
interface sample_stream_ctrl_if #(
    parameter int BPS        = 24,
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic           in_enable;
    logic           in_uart_ready;
    logic [7:0]     in_uart_frame;
    logic           in_clear_flags;
    logic [BPS-1:0] out_sample;
    logic           out_valid;
    logic           out_playing;
    logic           out_overrun;
    logic           out_underrun;
    logic           out_resync;
    logic [LW-1:0]  out_fill_level;

    modport master (
        output in_enable, in_uart_ready, in_uart_frame, in_clear_flags,
        input  out_sample, out_valid, out_playing, out_overrun,
               out_underrun, out_resync, out_fill_level
    );

    modport slave (
        input  in_enable, in_uart_ready, in_uart_frame, in_clear_flags,
        output out_sample, out_valid, out_playing, out_overrun,
               out_underrun, out_resync, out_fill_level
    );
endinterface

// File: rtl/sample_stream_ctrl.sv
// Purpose: UART bytes -> BPS-bit samples -> FIFO -> one sample per rate tick.
// Latency: sample enters the FIFO 1 cycle after its last byte; output registered 1 cycle after tick.
// Backpressure: none upstream; a completed sample arriving at a full FIFO is dropped and flagged.
// Ports: in_clk / in_rst_n plus the sample_stream_ctrl_if.slave bundle (UART byte strobe in,
//        enable, flag clear; sample/valid strobe out, playing, sticky overrun/underrun,
//        resync pulse, FIFO fill level).

// Generic single-clock FIFO with combinational head; push into a full FIFO is
// accepted only when a pop happens in the same cycle. Flush empties it.
module sample_stream_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push_vld,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push_vld && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

module sample_stream_ctrl #(
    parameter int BPS         = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int SAMPLE_DIV  = 2083,
    parameter int GAP_TIMEOUT = 100000
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    sample_stream_ctrl_if.slave bus
);
    localparam int BYTES = BPS / 8;
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW   = $clog2(BYTES + 1);
    localparam int DIVW  = $clog2(SAMPLE_DIV + 1);
    localparam int GAPW  = $clog2(GAP_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;

    logic [1:0]      r_state;
    logic [BCW-1:0]  r_byte_cnt;
    logic [BPS-1:0]  r_asm;
    logic            r_push_vld;
    logic [GAPW-1:0] r_gap_cnt;
    logic            r_resync;
    logic [DIVW-1:0] r_div;
    logic [BPS-1:0]  r_sample;
    logic            r_valid;
    logic            r_overrun;
    logic            r_underrun;

    logic            w_last_byte;
    logic            w_gap_to;
    logic            w_tick;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [BPS-1:0]  w_head;
    logic [LW-1:0]   w_count;
    logic            w_over_set;
    logic            w_under_set;

    assign w_last_byte = bus.in_uart_ready && (r_byte_cnt == BCW'(BYTES - 1));
    // A byte in the timeout cycle wins: the timeout only fires on an idle cycle.
    assign w_gap_to    = !bus.in_uart_ready && (r_byte_cnt != '0) &&
                         (r_gap_cnt == GAPW'(GAP_TIMEOUT - 1));
    assign w_tick      = bus.in_enable && (r_div == DIVW'(SAMPLE_DIV - 1));
    assign w_pop       = (r_state == S_PLAY) && w_tick && !w_empty;
    // A pop in the same cycle makes room, so that push is not an overrun.
    assign w_over_set  = bus.in_enable && r_push_vld && w_full && !w_pop;
    assign w_under_set = (r_state == S_PLAY) && w_tick && w_empty;

    // Byte assembly and gap recovery. The sample is pushed straight from r_asm
    // the cycle after its last byte; a new byte landing in that same cycle
    // overwrites r_asm only after the FIFO has captured the old value.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_push_vld <= 1'b0;
            r_gap_cnt  <= '0;
            r_resync   <= 1'b0;
        end else if (!bus.in_enable) begin
            r_byte_cnt <= '0;
            r_push_vld <= 1'b0;
            r_gap_cnt  <= '0;
            r_resync   <= 1'b0;
        end else begin
            r_push_vld <= w_last_byte;
            r_resync   <= w_gap_to;
            if (bus.in_uart_ready) begin
                r_gap_cnt                      <= '0;
                r_asm[{r_byte_cnt, 3'b000} +: 8] <= bus.in_uart_frame;
                r_byte_cnt                     <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
            end else if (r_byte_cnt != '0) begin
                if (w_gap_to) begin
                    r_byte_cnt <= '0;
                    r_gap_cnt  <= '0;
                end else begin
                    r_gap_cnt  <= r_gap_cnt + 1'b1;
                end
            end
        end
    end

    // Sample-rate divider, held at 0 while disabled so cadence restarts on enable.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)                r_div <= '0;
        else if (!bus.in_enable || w_tick) r_div <= '0;
        else                          r_div <= r_div + 1'b1;
    end

    sample_stream_fifo #(
        .W     (BPS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (in_clk),
        .i_rst_n    (in_rst_n),
        .i_flush    (!bus.in_enable),
        .i_push_vld (r_push_vld),
        .i_push_dat (r_asm),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Playback FSM. FILL still emits silence on every tick so the DAC keeps its cadence.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state    <= S_IDLE;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!bus.in_enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_FILL;
                    S_FILL: begin
                        if (w_tick) begin
                            r_valid  <= 1'b1;
                            r_sample <= '0;
                        end
                        if (w_count >= LW'(FIFO_DEPTH / 2)) r_state <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (w_tick) begin
                            r_valid <= 1'b1;
                            if (!w_empty) begin
                                r_sample <= w_head;
                            end else begin
                                r_sample <= '0;
                                r_state  <= S_FILL;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // Set has priority over a same-cycle clear.
            if (w_over_set)               r_overrun  <= 1'b1;
            else if (bus.in_clear_flags)  r_overrun  <= 1'b0;
            if (w_under_set)              r_underrun <= 1'b1;
            else if (bus.in_clear_flags)  r_underrun <= 1'b0;
        end
    end

    assign bus.out_sample     = r_sample;
    assign bus.out_valid      = r_valid;
    assign bus.out_playing    = (r_state == S_PLAY);
    assign bus.out_overrun    = r_overrun;
    assign bus.out_underrun   = r_underrun;
    assign bus.out_resync     = r_resync;
    assign bus.out_fill_level = w_count;
endmodule

// File: tb/tb_sample_stream_ctrl.sv
// Bench for sample_stream_ctrl: table of byte triplets with their expected
// little-endian samples, a queue of expected DAC outputs popped on every
// out_valid while monitoring is armed, and hand-timed corner sequences.
module tb_sample_stream_ctrl;
    localparam int BPS   = 24;
    localparam int DEPTH = 16;
    localparam int SDIV  = 300;
    localparam int GAP   = 150;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [7:0]     b0;
        logic [7:0]     b1;
        logic [7:0]     b2;
        logic [BPS-1:0] exp;
    } vec_t;

    logic in_clk = 1'b0;
    logic in_rst_n;
    always #5 in_clk = ~in_clk;

    sample_stream_ctrl_if #(.BPS(BPS), .FIFO_DEPTH(DEPTH)) bus ();

    sample_stream_ctrl #(
        .BPS         (BPS),
        .FIFO_DEPTH  (DEPTH),
        .SAMPLE_DIV  (SDIV),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .bus      (bus)
    );

    int             n_checks = 0;
    int             n_errors = 0;
    int             n_valid  = 0;
    int             cyc      = 0;
    int             last_valid_cyc = 0;
    bit             mon_en   = 1'b0;
    logic [BPS-1:0] exp_q [$];
    vec_t           tbl [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: sample #1 after the edge and feed the scoreboard.
    task automatic step();
        @(posedge in_clk);
        #1;
        cyc++;
        if (bus.out_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (mon_en) begin
                if (exp_q.size() == 0) check("unexpected_valid", 32'(bus.out_sample), 32'hFFFF_FFFF);
                else                   check("sample", 32'(bus.out_sample), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_uart_ready = 1'b1;
        bus.in_uart_frame = b;
        step();
        bus.in_uart_ready = 1'b0;
        step();
    endtask

    task automatic send_sample(input vec_t v);
        send_byte(v.b0);
        send_byte(v.b1);
        send_byte(v.b2);
    endtask

    task automatic wait_valids(input int n, input int bound, input string nm);
        int got = 0;
        int k   = 0;
        while (got < n && k < bound) begin
            step();
            k++;
            if (bus.out_valid === 1'b1) got++;
        end
        check(nm, 32'(got), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int k;
        bit seen;
        int lv;

        tbl[0]  = '{8'h01, 8'h02, 8'h03, 24'h030201};
        tbl[1]  = '{8'h10, 8'h20, 8'h30, 24'h302010};
        tbl[2]  = '{8'h11, 8'h12, 8'h13, 24'h131211};
        tbl[3]  = '{8'hA5, 8'h5A, 8'h0F, 24'h0F5AA5};
        tbl[4]  = '{8'hFF, 8'h00, 8'h80, 24'h8000FF};
        tbl[5]  = '{8'h34, 8'h12, 8'h00, 24'h001234};
        tbl[6]  = '{8'h00, 8'h00, 8'h01, 24'h010000};
        tbl[7]  = '{8'h7E, 8'h7F, 8'h80, 24'h807F7E};
        tbl[8]  = '{8'h21, 8'h43, 8'h65, 24'h654321};
        tbl[9]  = '{8'hEF, 8'hBE, 8'hAD, 24'hADBEEF};
        tbl[10] = '{8'h01, 8'h00, 8'h00, 24'h000001};
        tbl[11] = '{8'hC0, 8'hFF, 8'hEE, 24'hEEFFC0};
        tbl[12] = '{8'h99, 8'h88, 8'h77, 24'h778899};
        tbl[13] = '{8'h0A, 8'h0B, 8'h0C, 24'h0C0B0A};
        tbl[14] = '{8'hF0, 8'h0F, 8'hF0, 24'hF00FF0};
        tbl[15] = '{8'h5C, 8'h4B, 8'h3A, 24'h3A4B5C};

        in_rst_n           = 1'b0;
        bus.in_enable      = 1'b0;
        bus.in_uart_ready  = 1'b0;
        bus.in_uart_frame  = 8'h00;
        bus.in_clear_flags = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid",    32'(bus.out_valid),      32'd0);
        check("rst_sample",   32'(bus.out_sample),     32'd0);
        check("rst_playing",  32'(bus.out_playing),    32'd0);
        check("rst_overrun",  32'(bus.out_overrun),    32'd0);
        check("rst_underrun", 32'(bus.out_underrun),   32'd0);
        check("rst_resync",   32'(bus.out_resync),     32'd0);
        check("rst_fill",     32'(bus.out_fill_level), 32'd0);
        in_rst_n = 1'b1;
        step();

        // 1: one sample buffered, silence ticks in FILL
        bus.in_enable = 1'b1;
        v0 = n_valid;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t1_fill", 32'(bus.out_fill_level), 32'd1);
        check("t1_no_valid_before_tick", 32'(n_valid - v0), 32'd0);
        mon_en = 1'b1;
        exp_q.push_back(24'h000000);
        wait_valids(1, SDIV + 10, "t1_tick");
        check("t1_playing", 32'(bus.out_playing), 32'd0);
        step();
        check("t1_valid_one_cycle", 32'(bus.out_valid), 32'd0);

        // 2: reach half full, play in order, underrun on the 9th tick
        exp_q.push_back(24'h332211);
        for (int i = 1; i <= 7; i++) begin
            send_sample(tbl[i]);
            exp_q.push_back(tbl[i].exp);
        end
        step();
        check("t2_fill", 32'(bus.out_fill_level), 32'd8);
        check("t2_playing", 32'(bus.out_playing), 32'd1);
        wait_valids(8, 8 * SDIV + 20, "t2_drain");
        exp_q.push_back(24'h000000);
        wait_valids(1, SDIV + 10, "t2_underrun_tick");
        check("t2_underrun", 32'(bus.out_underrun), 32'd1);
        check("t2_playing_off", 32'(bus.out_playing), 32'd0);
        bus.in_clear_flags = 1'b1;
        step();
        bus.in_clear_flags = 1'b0;
        check("t2_underrun_clr", 32'(bus.out_underrun), 32'd0);

        // 3: partial sample discarded after a line gap, alignment recovered
        mon_en = 1'b0;
        send_byte(8'h55);
        send_byte(8'h66);
        k = 0;
        seen = 1'b0;
        while (!seen && k < GAP + 20) begin
            step();
            k++;
            if (bus.out_resync === 1'b1) seen = 1'b1;
        end
        check("t3_resync_seen", 32'(seen), 32'd1);
        check("t3_resync_timing", 32'((k >= GAP - 2) && (k <= GAP + 2)), 32'd1);
        step();
        check("t3_resync_pulse", 32'(bus.out_resync), 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("t3_fill", 32'(bus.out_fill_level), 32'd1);

        // 5: push completing on the same edge as a PLAY pop
        wait_valids(1, SDIV + 10, "t5_sync");
        mon_en = 1'b1;
        exp_q.push_back(24'hCCBBAA);
        for (int i = 8; i <= 14; i++) begin
            send_sample(tbl[i]);
            exp_q.push_back(tbl[i].exp);
        end
        step();
        check("t5_fill_half", 32'(bus.out_fill_level), 32'd8);
        check("t5_playing", 32'(bus.out_playing), 32'd1);
        lv = last_valid_cyc;
        while (cyc < lv + SDIV - 6) step();
        send_byte(tbl[15].b0);
        send_byte(tbl[15].b1);
        exp_q.push_back(tbl[15].exp);
        bus.in_uart_ready = 1'b1;
        bus.in_uart_frame = tbl[15].b2;
        step();
        bus.in_uart_ready = 1'b0;
        check("t5_fill_pre", 32'(bus.out_fill_level), 32'd8);
        step();
        check("t5_pop_same_edge", 32'(bus.out_valid), 32'd1);
        check("t5_fill_unchanged", 32'(bus.out_fill_level), 32'd8);

        // 6: disable mid-sample with 5 samples buffered
        wait_valids(3, 3 * SDIV + 10, "t6_drain3");
        check("t6_fill5", 32'(bus.out_fill_level), 32'd5);
        send_byte(8'h77);
        bus.in_enable = 1'b0;
        step();
        check("t6_flush", 32'(bus.out_fill_level), 32'd0);
        check("t6_idle", 32'(bus.out_playing), 32'd0);
        mon_en = 1'b0;
        exp_q.delete();
        v0 = n_valid;
        repeat (20) step();
        check("t6_no_valid", 32'(n_valid - v0), 32'd0);

        // 4: 17 samples with no tick -> full, 17th lost; first sample aligned from byte 0
        bus.in_enable = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_sample(tbl[i]);
            exp_q.push_back(tbl[i].exp);
        end
        check("t4_no_overrun_yet", 32'(bus.out_overrun), 32'd0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        step();
        check("t4_fill_full", 32'(bus.out_fill_level), 32'd16);
        check("t4_overrun", 32'(bus.out_overrun), 32'd1);
        bus.in_clear_flags = 1'b1;
        step();
        bus.in_clear_flags = 1'b0;
        check("t4_overrun_clr", 32'(bus.out_overrun), 32'd0);
        wait_valids(3, 3 * SDIV + 10, "t4_play3");
        mon_en = 1'b0;
        exp_q.delete();

        // Reset mid-sample and mid-FIFO
        send_byte(8'h99);
        in_rst_n = 1'b0;
        step();
        check("rst2_fill", 32'(bus.out_fill_level), 32'd0);
        check("rst2_playing", 32'(bus.out_playing), 32'd0);
        check("rst2_valid", 32'(bus.out_valid), 32'd0);
        in_rst_n = 1'b1;
        step();
        send_byte(8'h10);
        send_byte(8'h20);
        check("rst2_partial", 32'(bus.out_fill_level), 32'd0);
        send_byte(8'h30);
        check("rst2_aligned", 32'(bus.out_fill_level), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
